// File: rtl/ring_mix.sv
// Wet/dry mixer: blends a clamped dry sample with a ring-modulator result and
// emits the mix as an offset-binary DAC word, with a bounded ring handshake.
module ring_mix #(
   parameter logic signed [19:0] SAMPLE_OFFSET = 20'sh7FFF,
   parameter logic [5:0]         TIMEOUT       = 6'd40
) (
   input  logic               i_Clock,
   input  logic               i_Reset_N,
   input  logic               i_Start,
   input  logic signed [19:0] i_Dry_Sample,
   input  logic [11:0]        i_Mix,
   input  logic signed [15:0] i_Ring_Result,
   input  logic               i_Ring_Ready,
   output logic               o_Ring_Start,
   output logic [15:0]        o_Sample,
   output logic               o_Valid,
   output logic               o_Busy,
   output logic               o_Timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT, S_MULT, S_SUM, S_CLAMP, S_OUT
   } state_e;

   localparam logic signed [19:0] NEG_OFF = -SAMPLE_OFFSET;
   localparam logic signed [29:0] OFF30   = {{10{SAMPLE_OFFSET[19]}}, SAMPLE_OFFSET};
   localparam logic signed [29:0] NOFF30  = -OFF30;

   state_e             state_q, state_d;
   logic signed [15:0] dry_q, dry_d, wet_q, wet_d, clamp_q, clamp_d;
   logic [12:0]        mix_q, mix_d;
   logic [5:0]         cnt_q, cnt_d;
   logic signed [28:0] pwet_q, pwet_d, pdry_q, pdry_d;
   logic signed [29:0] acc_q, acc_d;
   logic [15:0]        sample_q, sample_d;
   logic               valid_q, valid_d, rstart_q, rstart_d, to_q, to_d;

   logic signed [19:0] dry_sat;
   logic signed [28:0] wet_ext, dry_ext, mw_ext, md_ext;
   logic signed [29:0] sum30;

   always_comb begin
      state_d  = state_q;
      dry_d    = dry_q;
      wet_d    = wet_q;
      mix_d    = mix_q;
      cnt_d    = cnt_q;
      pwet_d   = pwet_q;
      pdry_d   = pdry_q;
      acc_d    = acc_q;
      clamp_d  = clamp_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      rstart_d = 1'b0;
      to_d     = to_q;

      if (i_Dry_Sample > SAMPLE_OFFSET)      dry_sat = SAMPLE_OFFSET;
      else if (i_Dry_Sample < NEG_OFF)       dry_sat = NEG_OFF;
      else                                   dry_sat = i_Dry_Sample;

      wet_ext = {{13{wet_q[15]}}, wet_q};
      dry_ext = {{13{dry_q[15]}}, dry_q};
      mw_ext  = {16'd0, mix_q};
      md_ext  = {16'd0, 13'd4096 - mix_q};
      sum30   = {pwet_q[28], pwet_q} + {pdry_q[28], pdry_q};

      case (state_q)
         S_IDLE: if (i_Start) begin
            dry_d    = dry_sat[15:0];
            mix_d    = (i_Mix == 12'd4095) ? 13'd4096 : {1'b0, i_Mix};
            rstart_d = 1'b1;
            to_d     = 1'b0;
            cnt_d    = '0;
            state_d  = S_ARM;
         end
         // Running out of budget in ARM wins over seeing ready drop.
         S_ARM: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_d >= TIMEOUT) begin
               to_d    = 1'b1;
               wet_d   = dry_q;
               state_d = S_MULT;
            end else if (!i_Ring_Ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 6'd1;
            if (i_Ring_Ready) begin
               wet_d   = i_Ring_Result;
               state_d = S_MULT;
            end else if (cnt_d >= TIMEOUT) begin
               to_d    = 1'b1;
               wet_d   = dry_q;
               state_d = S_MULT;
            end
         end
         S_MULT: begin
            pwet_d  = wet_ext * mw_ext;
            pdry_d  = dry_ext * md_ext;
            state_d = S_SUM;
         end
         S_SUM: begin
            acc_d   = sum30 >>> 12;
            state_d = S_CLAMP;
         end
         S_CLAMP: begin
            if (acc_q > OFF30)       clamp_d = OFF30[15:0];
            else if (acc_q < NOFF30) clamp_d = NOFF30[15:0];
            else                     clamp_d = acc_q[15:0];
            state_d = S_OUT;
         end
         S_OUT: begin
            sample_d = clamp_q + 16'h8000;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         state_q  <= S_IDLE;
         dry_q    <= '0;
         wet_q    <= '0;
         mix_q    <= '0;
         cnt_q    <= '0;
         pwet_q   <= '0;
         pdry_q   <= '0;
         acc_q    <= '0;
         clamp_q  <= '0;
         sample_q <= 16'h8000;
         valid_q  <= 1'b0;
         rstart_q <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         dry_q    <= dry_d;
         wet_q    <= wet_d;
         mix_q    <= mix_d;
         cnt_q    <= cnt_d;
         pwet_q   <= pwet_d;
         pdry_q   <= pdry_d;
         acc_q    <= acc_d;
         clamp_q  <= clamp_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         rstart_q <= rstart_d;
         to_q     <= to_d;
      end
   end

   assign o_Ring_Start = rstart_q;
   assign o_Sample     = sample_q;
   assign o_Valid      = valid_q;
   assign o_Busy       = (state_q != S_IDLE);
   assign o_Timeout    = to_q;

endmodule

// File: tb/tb_ring_mix.sv
// Directed bench for ring_mix: a per-cycle checker compares every output
// against an arithmetic mixing/handshake model; literals pin key results.
module tb_ring_mix;
   localparam int TMO = 40;

   logic               i_Clock = 1'b0;
   logic               i_Reset_N = 1'b0;
   logic               i_Start = 1'b0;
   logic signed [19:0] i_Dry_Sample = '0;
   logic [11:0]        i_Mix = '0;
   logic signed [15:0] i_Ring_Result = '0;
   logic               i_Ring_Ready = 1'b1;
   logic               o_Ring_Start, o_Valid, o_Busy, o_Timeout;
   logic [15:0]        o_Sample;

   ring_mix dut (
      .i_Clock(i_Clock), .i_Reset_N(i_Reset_N), .i_Start(i_Start),
      .i_Dry_Sample(i_Dry_Sample), .i_Mix(i_Mix), .i_Ring_Result(i_Ring_Result),
      .i_Ring_Ready(i_Ring_Ready), .o_Ring_Start(o_Ring_Start), .o_Sample(o_Sample),
      .o_Valid(o_Valid), .o_Busy(o_Busy), .o_Timeout(o_Timeout)
   );

   initial forever #5 i_Clock = ~i_Clock;

   int checks = 0, failures = 0, cyc = 0;
   bit chk_en = 1'b0;
   // model of the transaction in flight (or most recently finished)
   int t_start = -1000, m_lat = 5, m_n = 0;
   logic [15:0] m_sample = 16'h8000, prev_sample = 16'h8000;
   bit m_to = 1'b0, prev_to = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   initial forever begin
      @(posedge i_Clock);
      #1;
      cyc++;
      if (chk_en) begin
         int rel;
         rel = cyc - t_start;
         chk("ring_start", 32'(o_Ring_Start), 32'(rel == 1));
         chk("valid", 32'(o_Valid), 32'(rel == m_lat));
         chk("busy", 32'(o_Busy), 32'(rel >= 1 && rel < m_lat));
         chk("timeout", 32'(o_Timeout), 32'((rel <= 0) ? prev_to : (rel <= m_n) ? 1'b0 : m_to));
         chk("sample", 32'(o_Sample), 32'((rel < m_lat) ? prev_sample : m_sample));
      end
   end

   // Ring ready is high except low for cycles d+1..d+L after the start cycle.
   task automatic run(input logic signed [19:0] dry, input logic [11:0] mix,
                      input logic signed [15:0] ring, input int d, input int L,
                      input bit pre_low, input int busy_rel, input int rst_rel,
                      output int mlat);
      longint dc, m, w, s;
      int c1;
      bit ok;
      dc = dry;
      if (dc > 32767) dc = 32767;
      if (dc < -32767) dc = -32767;
      m  = (mix == 12'd4095) ? 4096 : longint'(mix);
      c1 = d + L + 1;
      ok = (L > 0) && (c1 <= TMO);
      w  = ok ? longint'(ring) : dc;
      s  = (w * m + dc * (4096 - m)) >>> 12;
      if (s > 32767) s = 32767;
      if (s < -32767) s = -32767;
      prev_sample = m_sample;
      prev_to     = m_to;
      m_sample    = 16'(s + 32768);
      m_to        = !ok;
      m_n         = ok ? c1 : TMO;
      m_lat       = m_n + 5;
      t_start     = cyc;
      i_Start = 1'b1; i_Dry_Sample = dry; i_Mix = mix; i_Ring_Result = ring;
      i_Ring_Ready = !pre_low;
      mlat = -1;
      for (int r = 1; r <= 60; r++) begin
         @(negedge i_Clock);
         if (r == rst_rel) begin
            chk_en = 1'b0;
            i_Reset_N = 1'b0;
            #1;
            chk("rst_async_sample", 32'(o_Sample), 32'h8000);
            chk("rst_async_busy", 32'(o_Busy), 32'd0);
            chk("rst_async_valid", 32'(o_Valid), 32'd0);
            chk("rst_async_tmo", 32'(o_Timeout), 32'd0);
            i_Start = 1'b0; i_Ring_Ready = 1'b1;
            repeat (3) begin
               @(negedge i_Clock);
               chk("rst_no_valid", 32'(o_Valid), 32'd0);
               chk("rst_ring_start", 32'(o_Ring_Start), 32'd0);
            end
            i_Reset_N = 1'b1;
            m_sample = 16'h8000; m_to = 1'b0; t_start = -1000; m_lat = 5;
            chk_en = 1'b1;
            mlat = 0;
            break;
         end
         if (o_Valid && mlat < 0) mlat = r;
         i_Start      = (r == busy_rel);
         i_Dry_Sample = ~dry;
         i_Mix        = ~mix;
         i_Ring_Ready = !(r > d && r <= d + L);
         if (r > m_lat) break;
      end
      if (mlat < 0) chk("valid_seen", 32'd0, 32'd1);
      i_Start = 1'b0;
      i_Ring_Ready = 1'b1;
      repeat (2) @(negedge i_Clock);
   endtask

   initial begin
      int lat;
      repeat (2) @(negedge i_Clock);
      chk("reset_sample", 32'(o_Sample), 32'h8000);
      chk("reset_valid", 32'(o_Valid), 32'd0);
      chk("reset_busy", 32'(o_Busy), 32'd0);
      chk("reset_ring_start", 32'(o_Ring_Start), 32'd0);
      chk("reset_timeout", 32'(o_Timeout), 32'd0);
      i_Reset_N = 1'b1;
      chk_en = 1'b1;
      @(negedge i_Clock);

      run(20'sh01000, 12'd0, 16'sh7000, 0, 2, 1'b0, 0, 0, lat);
      chk("dry_only_lit", 32'(o_Sample), 32'h9000);
      chk("dry_only_lat", 32'(lat), 32'd8);
      run(20'sh00000, 12'd4095, 16'shC000, 1, 3, 1'b0, 0, 0, lat);
      chk("wet_only_lit", 32'(o_Sample), 32'h4000);
      run(20'sh40000, 12'd2048, 16'sh7FFF, 0, 1, 1'b0, 0, 0, lat);
      chk("half_pos_clamp_lit", 32'(o_Sample), 32'hFFFF);
      run(20'shC0000, 12'd2048, 16'sh8000, 0, 1, 1'b0, 0, 0, lat);
      chk("half_neg_clamp_lit", 32'(o_Sample), 32'h0001);
      run(20'sh01000, 12'd1000, 16'sh1234, 0, 0, 1'b0, 0, 0, lat);
      chk("timeout_lit", 32'(o_Timeout), 32'd1);
      chk("timeout_sample_lit", 32'(o_Sample), 32'h9000);
      chk("timeout_lat", 32'(lat), 32'd45);
      run(20'sh00100, 12'd1024, 16'sh2000, 0, 7, 1'b0, 3, 0, lat);
      chk("handshake_lat", 32'(lat), 32'd13);
      chk("handshake_lit", 32'(o_Sample), 32'h88C0);
      chk("timeout_cleared", 32'(o_Timeout), 32'd0);
      run(20'shFFF9C, 12'd300, -16'sd5000, 2, 1, 1'b0, 0, 0, lat);
      run(20'sh00321, 12'd3000, 16'sh0ABC, 0, 4, 1'b1, 0, 0, lat);
      chk("pre_low_lat", 32'(lat), 32'd10);
      run(20'sh02000, 12'd500, 16'sh0100, 0, 3, 1'b0, 0, 5, lat);
      run(20'sh00500, 12'd4095, -16'sd1, 0, 2, 1'b0, 0, 0, lat);
      chk("after_reset_lit", 32'(o_Sample), 32'h7FFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ring_mix.md
RING_MIX -- requirements
Module: ring_mix

Interface
REQ-001 SHALL have parameter SAMPLE_OFFSET, default 20'sh7FFF, meaning the symmetric saturation limit (+/-) for all signed samples.
REQ-002 SHALL have parameter TIMEOUT, default 6'd40, meaning the maximum i_Clock cycles spent waiting for the ring modulator.
REQ-003 SHALL have port i_Clock  input  1  meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset_N  input  1  meaning the reset; asynchronous and active-low.
REQ-005 SHALL have port i_Start  input  1  meaning a request to produce one mixed sample, sampled only in IDLE.
REQ-006 SHALL have port i_Dry_Sample  input  20 signed  meaning the unprocessed additive-oscillator sample.
REQ-007 SHALL have port i_Mix  input  12 unsigned  meaning the wet/dry control: 0 is all dry, 4095 is all wet.
REQ-008 SHALL have port i_Ring_Result  input  16 signed  meaning the ring-modulator output.
REQ-009 SHALL have port i_Ring_Ready  input  1  meaning ring modulator idle/done; low while it is calculating.
REQ-010 SHALL have port o_Ring_Start  output  1  meaning a one-cycle start pulse to the ring modulator.
REQ-011 SHALL have port o_Sample  output  16 unsigned  meaning the mixed sample in offset-binary format for the DAC.
REQ-012 SHALL have port o_Valid  output  1  meaning a one-cycle pulse marking a new o_Sample.
REQ-013 SHALL have port o_Busy  output  1  meaning high in every state except IDLE.
REQ-014 SHALL have port o_Timeout  output  1  meaning a sticky flag set when the ring modulator failed to respond within TIMEOUT cycles; cleared by the next i_Start.

Function
REQ-015 SHALL implement the states IDLE, ARM, WAIT, MULT, SUM, CLAMP and OUT.
REQ-016 IDLE SHALL do the following on i_Start=1:
  - latch the dry sample, clamped to +/-SAMPLE_OFFSET and truncated to 16 bits signed;
  - latch the effective mix m_eff, where i_Mix=4095 maps to 4096, otherwise m_eff = i_Mix;
  - pulse o_Ring_Start, clear o_Timeout and the timeout counter, then go to ARM.
REQ-017 ARM SHALL wait for i_Ring_Ready=0, then go to WAIT.
REQ-018 WAIT SHALL wait for i_Ring_Ready=1, then latch i_Ring_Result as the wet sample and go to MULT.
REQ-019 The timeout counter SHALL increment each cycle in ARM or WAIT. On reaching TIMEOUT it SHALL set o_Timeout, set the wet sample equal to the dry sample, and go to MULT.
REQ-020 MULT SHALL compute two 29-bit signed products: P_wet = wet*m_eff and P_dry = dry*(4096-m_eff).
REQ-021 SUM SHALL compute S = (P_wet + P_dry) >>> 12 (arithmetic shift) in a 30-bit signed accumulator.
REQ-022 CLAMP SHALL saturate S to the range [-SAMPLE_OFFSET, +SAMPLE_OFFSET].
REQ-023 OUT SHALL set o_Sample = clamped value + 16'h8000 (mod 2^16), pulse o_Valid for exactly one cycle, and return to IDLE.
REQ-024 Latency from i_Start to o_Valid SHALL be (ARM+WAIT cycles) + 5.
REQ-025 i_Start SHALL be ignored while o_Busy=1; no queuing.
REQ-026 Changes to i_Dry_Sample and i_Mix after the i_Start cycle SHALL NOT affect the current result.
REQ-027 o_Sample SHALL hold its value between o_Valid pulses.
REQ-028 If i_Ring_Ready is already low at i_Start, ARM SHALL exit on the next cycle. A ready glitch (low then high) inside ARM/WAIT SHALL be accepted as completion.

Reset
REQ-029 While i_Reset_N=0 the block SHALL immediately hold the following values:
  - state IDLE;
  - o_Sample = 16'h8000 (midscale);
  - o_Valid, o_Ring_Start, o_Busy and o_Timeout = 0;
  - all internal registers = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no o_Valid pulse. The first i_Start after reset release SHALL be honoured from IDLE.

Verification
REQ-031 Dry only: i_Mix=0, i_Dry_Sample=20'sh01000, ring returns 16'sh7000 -> o_Sample=16'h9000, o_Timeout=0.
REQ-032 Wet only: i_Mix=4095, i_Dry_Sample=0, ring returns 16'shC000 (-16384) -> o_Sample=16'h4000.
REQ-033 Half mix and clamp: i_Mix=2048, dry=20'sh40000 (clamps to 32767), ring=32767 -> o_Sample=16'hFFFF. Then dry=-20'sh40000, ring=-32768 -> o_Sample=16'h0001.
REQ-034 Timeout: i_Ring_Ready held at 1 -> o_Timeout=1 after TIMEOUT cycles, and o_Sample equals the dry-only result. The next i_Start clears o_Timeout.
REQ-035 Latency and handshake: ring model drops ready for 7 cycles -> o_Ring_Start is a single pulse, o_Valid arrives exactly at the REQ-024 latency, and an i_Start pulsed while busy is ignored.
REQ-036 Reset mid-op: assert i_Reset_N=0 in MULT -> outputs take reset values asynchronously, no o_Valid, and a clean result follows the next i_Start.
